// File: rtl/bram_cam.sv
`default_nettype none
// ============================================================================
// Module   : bram_cam (with ram_dp, priority_encoder)
// Brief    : Block-RAM CAM; sliced one-hot match bitmaps plus a key shadow RAM.
// Revision : 1.0 - initial release
// ============================================================================

module ram_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    output logic [DATA_WIDTH-1:0] o_a_dout,
    input  logic                  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_din,
    output logic [DATA_WIDTH-1:0] o_b_dout
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Both ports read-first; only port B writes.
    always_ff @(posedge clk) begin
        o_a_dout <= r_mem[i_a_addr];
        o_b_dout <= r_mem[i_b_addr];
        if (i_b_we)
            r_mem[i_b_addr] <= i_b_din;
    end
endmodule

module priority_encoder #(
    parameter int WIDTH     = 32,
    parameter int LSB_WIDTH = 5
) (
    input  logic [WIDTH-1:0]     i_req,
    output logic                 o_valid,
    output logic [LSB_WIDTH-1:0] o_index,
    output logic [WIDTH-1:0]     o_onehot
);
    always_comb begin
        o_valid  = |i_req;
        o_index  = '0;
        o_onehot = i_req & (~i_req + WIDTH'(1));
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i])
                o_index = LSB_WIDTH'(i);
        end
    end
endmodule

module bram_cam #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       write_delete,
    input  logic                       write_enable,
    output logic                       write_busy,
    input  logic [DATA_WIDTH-1:0]      compare_data,
    output logic [(2**ADDR_WIDTH)-1:0] match_many,
    output logic [(2**ADDR_WIDTH)-1:0] match_single,
    output logic [ADDR_WIDTH-1:0]      match_addr,
    output logic                       match
);
    localparam int c_ram_depth   = 2**ADDR_WIDTH;
    localparam int c_slice_count = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
    localparam int c_last_w      = DATA_WIDTH - SLICE_WIDTH * (c_slice_count - 1);

    localparam logic [2:0] c_st_init  = 3'd0;
    localparam logic [2:0] c_st_idle  = 3'd1;
    localparam logic [2:0] c_st_del1  = 3'd2;
    localparam logic [2:0] c_st_del2  = 3'd3;
    localparam logic [2:0] c_st_wr1   = 3'd4;
    localparam logic [2:0] c_st_wr2   = 3'd5;

    logic [2:0]             r_state;
    logic [SLICE_WIDTH-1:0] r_count;
    logic                   r_busy;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_delete;
    logic                   r_cmp_ok;

    logic [DATA_WIDTH-1:0]  r_shadow [c_ram_depth];
    logic [DATA_WIDTH-1:0]  r_shadow_q;

    logic [ADDR_WIDTH-1:0]  w_addr_d;
    logic                   w_sh_we;
    logic [ADDR_WIDTH-1:0]  w_sh_waddr;
    logic [DATA_WIDTH-1:0]  w_sh_wdata;
    logic [DATA_WIDTH-1:0]  w_key_b;
    logic                   w_init;
    logic                   w_b_we;
    logic [c_ram_depth-1:0] w_entry_bit;
    logic [c_ram_depth-1:0] w_clear;
    logic [c_ram_depth-1:0] w_set;
    logic [c_ram_depth-1:0] w_a_douts [c_slice_count];
    logic [c_ram_depth-1:0] w_match_and;
    logic                   w_pe_valid;

    assign write_busy = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_init;
            r_count  <= '1;
            r_busy   <= 1'b1;
            r_addr   <= '0;
            r_data   <= '0;
            r_delete <= 1'b0;
            r_cmp_ok <= 1'b0;
        end else begin
            // Gate compare results until the read that produced them saw a cleared RAM.
            r_cmp_ok <= (r_state != c_st_init);
            case (r_state)
                c_st_init: begin
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
                c_st_idle: begin
                    r_addr   <= write_addr;
                    r_data   <= write_data;
                    r_delete <= write_delete;
                    if (write_enable) begin
                        r_state <= c_st_del1;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_del1: r_state <= c_st_del2;
                c_st_del2: begin
                    if (r_delete) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= c_st_wr1;
                    end
                end
                c_st_wr1: r_state <= c_st_wr2;
                c_st_wr2: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_init;
                    r_count <= '1;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Shadow is read with the address about to be captured so the old key is ready in DELETE_1.
    assign w_addr_d   = (r_state == c_st_idle) ? write_addr : r_addr;
    assign w_init     = (r_state == c_st_init);
    // Zeroing the shadow during the init sweep keeps it consistent with the cleared bitmaps.
    assign w_sh_we    = w_init || ((r_state == c_st_del2) && !r_delete);
    assign w_sh_waddr = w_init ? ADDR_WIDTH'(r_count) : r_addr;
    assign w_sh_wdata = w_init ? '0 : r_data;

    always_ff @(posedge clk) begin
        r_shadow_q <= r_shadow[w_addr_d];
        if (w_sh_we)
            r_shadow[w_sh_waddr] <= w_sh_wdata;
    end

    assign w_key_b     = ((r_state == c_st_wr1) || (r_state == c_st_wr2)) ? r_data : r_shadow_q;
    assign w_entry_bit = c_ram_depth'(1) << r_addr;
    assign w_clear     = w_init ? '1 : ((r_state == c_st_del2) ? w_entry_bit : '0);
    assign w_set       = (r_state == c_st_wr2) ? w_entry_bit : '0;
    assign w_b_we      = w_init || (r_state == c_st_del2) || (r_state == c_st_wr2);

    for (genvar gi = 0; gi < c_slice_count; gi++) begin : g_slice
        localparam int c_aw = (gi == c_slice_count - 1) ? c_last_w : SLICE_WIDTH;
        logic [c_aw-1:0]        w_a_addr;
        logic [c_aw-1:0]        w_b_addr;
        logic [c_ram_depth-1:0] w_b_dout;
        logic [c_ram_depth-1:0] w_b_din;

        assign w_a_addr = compare_data[gi*SLICE_WIDTH +: c_aw];
        assign w_b_addr = w_init ? r_count[c_aw-1:0] : w_key_b[gi*SLICE_WIDTH +: c_aw];
        assign w_b_din  = (w_b_dout & ~w_clear) | w_set;

        ram_dp #(
            .DATA_WIDTH (c_ram_depth),
            .ADDR_WIDTH (c_aw)
        ) u_ram (
            .clk      (clk),
            .i_a_addr (w_a_addr),
            .o_a_dout (w_a_douts[gi]),
            .i_b_we   (w_b_we),
            .i_b_addr (w_b_addr),
            .i_b_din  (w_b_din),
            .o_b_dout (w_b_dout)
        );
    end

    always_comb begin
        w_match_and = '1;
        for (int i = 0; i < c_slice_count; i++)
            w_match_and = w_match_and & w_a_douts[i];
    end

    assign match_many = (r_cmp_ok && !w_init) ? w_match_and : '0;

    priority_encoder #(
        .WIDTH     (c_ram_depth),
        .LSB_WIDTH (ADDR_WIDTH)
    ) u_pe (
        .i_req    (match_many),
        .o_valid  (w_pe_valid),
        .o_index  (match_addr),
        .o_onehot (match_single)
    );

    assign match = w_pe_valid;
endmodule

`default_nettype wire

// File: tb/tb_bram_cam.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_cam
// Brief    : Self-checking bench for bram_cam: vector table plus compare scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_cam;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int RD = 32;
    localparam int OP_WR  = 0;
    localparam int OP_DEL = 1;
    localparam int OP_CMP = 2;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic          write_delete = 1'b0;
    logic          write_enable = 1'b0;
    logic          write_busy;
    logic [DW-1:0] compare_data = '0;
    logic [RD-1:0] match_many;
    logic [RD-1:0] match_single;
    logic [AW-1:0] match_addr;
    logic          match;

    always #5 clk = ~clk;

    bram_cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_delete (write_delete),
        .write_enable (write_enable),
        .write_busy   (write_busy),
        .compare_data (compare_data),
        .match_many   (match_many),
        .match_single (match_single),
        .match_addr   (match_addr),
        .match        (match)
    );

    typedef struct {
        int            op;
        logic [AW-1:0] addr;
        logic [DW-1:0] key;
        logic [RD-1:0] exp;
    } vec_t;

    typedef struct {
        logic [RD-1:0] exp;
        int            tag;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [AW-1:0] lowest(logic [RD-1:0] v);
        for (int i = 0; i < RD; i++)
            if (v[i]) return AW'(i);
        return '0;
    endfunction

    // Compare results appear one edge after the key is sampled.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("cmp%0d many", e.tag), 64'(match_many), 64'(e.exp));
            check($sformatf("cmp%0d single", e.tag), 64'(match_single), 64'(e.exp & (~e.exp + 1'b1)));
            check($sformatf("cmp%0d addr", e.tag), 64'(match_addr), 64'(lowest(e.exp)));
            check($sformatf("cmp%0d match", e.tag), 64'(match), 64'(|e.exp));
        end
    end

    task automatic do_op(int op, logic [AW-1:0] a, logic [DW-1:0] k);
        int n;
        @(negedge clk);
        check("idle before op", 64'(write_busy), 64'd0);
        write_addr   = a;
        write_data   = k;
        write_delete = (op == OP_DEL);
        write_enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                // A competing request while busy must be ignored.
                write_addr   = 5'd9;
                write_data   = 64'h77;
                write_delete = 1'b0;
            end
        end while (write_busy && n < 20);
        write_enable = 1'b0;
        check(op == OP_DEL ? "delete busy window" : "write busy window", 64'(n), op == OP_DEL ? 64'd3 : 64'd5);
    endtask

    task automatic wait_init(string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 100) check({name, " match during init"}, 64'(match), 64'd0);
        end while (write_busy && n < 2000);
        check({name, " init cycles"}, 64'(n), 64'd512);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_CMP, 5'd0,  64'h0,                     32'h0};
        vecs[1]  = '{OP_WR,  5'd3,  64'h0123_4567_89AB_CDEF,   32'h0};
        vecs[2]  = '{OP_CMP, 5'd0,  64'h0123_4567_89AB_CDEF,   32'h8};
        vecs[3]  = '{OP_WR,  5'd5,  64'hAA,                    32'h0};
        vecs[4]  = '{OP_WR,  5'd2,  64'hAA,                    32'h0};
        vecs[5]  = '{OP_CMP, 5'd0,  64'hAA,                    32'h24};
        vecs[6]  = '{OP_WR,  5'd3,  64'h55,                    32'h0};
        vecs[7]  = '{OP_CMP, 5'd0,  64'h0123_4567_89AB_CDEF,   32'h0};
        vecs[8]  = '{OP_CMP, 5'd0,  64'h55,                    32'h8};
        vecs[9]  = '{OP_DEL, 5'd2,  64'h0,                     32'h0};
        vecs[10] = '{OP_CMP, 5'd0,  64'hAA,                    32'h20};
        vecs[11] = '{OP_CMP, 5'd0,  64'h77,                    32'h0};
        vecs[12] = '{OP_WR,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF,   32'h0};
        vecs[13] = '{OP_WR,  5'd0,  64'h8000_0000_0000_0000,   32'h0};
        vecs[14] = '{OP_CMP, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF,   32'h8000_0000};
        vecs[15] = '{OP_CMP, 5'd0,  64'h8000_0000_0000_0000,   32'h1};
        vecs[16] = '{OP_CMP, 5'd0,  64'h8000_0000_0000_0055,   32'h0};
        vecs[17] = '{OP_DEL, 5'd7,  64'h0,                     32'h0};
        vecs[18] = '{OP_CMP, 5'd0,  64'h55,                    32'h8};
        vecs[19] = '{OP_CMP, 5'd0,  64'h0,                     32'h0};

        // Power-up reset
        repeat (3) @(negedge clk);
        check("busy in reset", 64'(write_busy), 64'd1);
        check("match in reset", 64'(match), 64'd0);
        rst_n = 1'b1;
        wait_init("reset");

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].op == OP_CMP) begin
                @(negedge clk);
                compare_data = vecs[i].key;
                sb_q.push_back('{vecs[i].exp, i});
            end else begin
                do_op(vecs[i].op, vecs[i].addr, vecs[i].key);
            end
        end
        drain();

        // Reset while the write sequence sits in WRITE_1
        @(negedge clk);
        compare_data = 64'h55;
        write_addr   = 5'd10;
        write_data   = 64'h99;
        write_delete = 1'b0;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("busy in WRITE_1", 64'(write_busy), 64'd1);
        check("match before mid reset", 64'(match), 64'd1);
        rst_n = 1'b0;
        #1;
        check("busy after mid reset", 64'(write_busy), 64'd1);
        check("match after mid reset", 64'(match), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init("mid reset");

        @(negedge clk); compare_data = 64'h55;                  sb_q.push_back('{32'h0, 100});
        @(negedge clk); compare_data = 64'hAA;                  sb_q.push_back('{32'h0, 101});
        @(negedge clk); compare_data = 64'hFFFF_FFFF_FFFF_FFFF; sb_q.push_back('{32'h0, 102});
        @(negedge clk); compare_data = 64'h99;                  sb_q.push_back('{32'h0, 103});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
